// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    localparam logic [BE_W-1:0]   BE_READ   = 4'b0000;
    localparam logic [ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    // One accepted transaction, latched at grant time.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   byteen;
        logic              owner;
        logic              oor;
    } txn_t;

    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr, input int unsigned words);
        return 32'({2'b00, addr[ADDR_W-1:2]}) >= 32'(words);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic idx
);

    assign valid = req0 | req1;
    assign idx   = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between the CPU data port and an auxiliary
// master, one transaction at a time, with a programmable access latency.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned DM_WORDS    = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [BE_W-1:0]   r0_byteen,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [BE_W-1:0]   r1_byteen,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_byteen,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               last, last_n;
    txn_t               txn, txn_n;
    logic               pick_valid, pick_idx;
    logic               r0_gnt_n, r1_gnt_n, r0_done_n, r1_done_n, r0_err_n, r1_err_n;
    logic [DATA_W-1:0]  r0_rdata_n, r1_rdata_n, cap_data;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BE_W-1:0]    sel_byteen;

    rr_pick2 u_pick (
        .req0  (r0_req),
        .req1  (r1_req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Winner's request fields, chosen by the picker.
    always_comb begin
        sel_addr   = r0_addr;
        sel_wdata  = r0_wdata;
        sel_byteen = r0_byteen;
        if (pick_idx == REQ_AUX) begin
            sel_addr   = r1_addr;
            sel_wdata  = r1_wdata;
            sel_byteen = r1_byteen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= REQ_AUX;
            txn      <= '0;
            r0_gnt   <= 1'b0;
            r1_gnt   <= 1'b0;
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            r0_err   <= 1'b0;
            r1_err   <= 1'b0;
            r0_rdata <= '0;
            r1_rdata <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last     <= last_n;
            txn      <= txn_n;
            r0_gnt   <= r0_gnt_n;
            r1_gnt   <= r1_gnt_n;
            r0_done  <= r0_done_n;
            r1_done  <= r1_done_n;
            r0_err   <= r0_err_n;
            r1_err   <= r1_err_n;
            r0_rdata <= r0_rdata_n;
            r1_rdata <= r1_rdata_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        last_n     = last;
        txn_n      = txn;
        r0_gnt_n   = 1'b0;
        r1_gnt_n   = 1'b0;
        r0_done_n  = 1'b0;
        r1_done_n  = 1'b0;
        r0_err_n   = 1'b0;
        r1_err_n   = 1'b0;
        r0_rdata_n = r0_rdata;
        r1_rdata_n = r1_rdata;
        cap_data   = txn.oor ? '0 : mem_rdata;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    txn_n.addr   = sel_addr & WORD_MASK;
                    txn_n.wdata  = sel_wdata;
                    txn_n.byteen = sel_byteen;
                    txn_n.owner  = pick_idx;
                    txn_n.oor    = addr_oor(sel_addr, DM_WORDS);
                    cnt_n        = CNT_W'(WAIT_CYCLES - 1);
                    r0_gnt_n     = (pick_idx == REQ_CPU);
                    r1_gnt_n     = (pick_idx == REQ_AUX);
                    state_n      = ACCESS;
                end
            end
            ACCESS: begin
                // Last access cycle: memory strobe fires and read data is captured.
                if (cnt == '0) begin
                    if (txn.owner == REQ_CPU) begin
                        r0_rdata_n = cap_data;
                        r0_done_n  = 1'b1;
                        r0_err_n   = txn.oor;
                    end else begin
                        r1_rdata_n = cap_data;
                        r1_done_n  = 1'b1;
                        r1_err_n   = txn.oor;
                    end
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                last_n  = txn.owner;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_addr  = txn.addr;
    assign mem_wdata = txn.wdata;
    // Reset gating keeps an aborted transaction from ever writing.
    assign mem_byteen = (state == ACCESS && cnt == '0 && !txn.oor && !reset) ? txn.byteen : BE_READ;

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Sequential arbiter that shares the single data-memory port (word address, 4-bit byte-enable write, combinational read data) between two requesters: the CPU M-stage data port (requester 0) and an auxiliary bus master such as a timer or loader (requester 1). It sits between the requesters and the data memory. It accepts one transaction at a time and grants round-robin when both requesters compete. It inserts a programmable number of access cycles and returns a one-cycle completion pulse with registered read data. It also blocks accesses to out-of-range addresses.

## Interface
- WAIT_CYCLES, 1: number of cycles spent in ACCESS per transaction; legal range 1..15.
- DM_WORDS, 4096: number of 32-bit words in data memory; word index ≥ DM_WORDS is out of range.

- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- r0_req / r1_req  in  1  request; held high until the matching done pulse.
- r0_addr / r1_addr  in  32  byte address.
- r0_wdata / r1_wdata  in  32  write data, already lane-aligned.
- r0_byteen / r1_byteen  in  4  byte enables; 4'b0000 means read.
- r0_gnt / r1_gnt  out  1  one-cycle pulse: transaction accepted.
- r0_done / r1_done  out  1  one-cycle pulse: transaction complete.
- r0_err / r1_err  out  1  qualifies done: address out of range.
- r0_rdata / r1_rdata  out  32  read data; valid in the done cycle and held until the next done to the same requester.
- mem_addr  out  32  word-aligned address (addr & 32'hFFFF_FFFC).
- mem_wdata  out  32  latched write data.
- mem_byteen  out  4  write strobe to memory.
- mem_rdata  in  32  combinational read data for mem_addr.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, pick the winner. A sole requester wins. If both request, the winner is the one not served last.
  - Latch the winner's addr, wdata, byteen and index. Go to ACCESS with cnt = WAIT_CYCLES-1.
- ACCESS:
  - The gnt pulse of the owner is high in the first ACCESS cycle.
  - mem_addr and mem_wdata are driven from the latch for the whole state.
  - cnt decrements each cycle. In the cycle where cnt==0:
    - mem_byteen = latched byteen. It is asserted exactly once per transaction.
    - mem_rdata is captured into the owner's rdata register.
    - The FSM goes to DONE.
- DONE:
  - Owner's done is high for one cycle. The last-served pointer is updated to the owner.
  - FSM returns to IDLE. A requester that keeps req high is re-arbitrated in the next IDLE cycle.
- Out of range (addr[31:2] ≥ DM_WORDS):
  - The full ACCESS sequence still runs, but mem_byteen stays 0 and rdata is loaded with 0.
  - err is asserted with done.
- Outside ACCESS: mem_byteen = 0, and mem_addr/mem_wdata hold their last values.
- Non-owner outputs (gnt, done, err) stay 0. Its rdata register holds its previous value.

## Timing
- Reset values:
  - State IDLE, cnt 0, last-served = 1 (requester 0 wins the first tie).
  - All gnt/done/err = 0, all rdata = 0.
  - mem_addr, mem_wdata = 0; mem_byteen = 0.
- mem_byteen is gated combinationally with ~reset, so no write is ever issued in a cycle with reset high.
- Latency: req first sampled high in IDLE at edge T gives gnt at T+1 and done at T+1+WAIT_CYCLES. For WAIT_CYCLES=1, done is at T+2.
- Back-to-back: after DONE at cycle D, the next grant is at D+2 at the earliest. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- Req dropped before done: the transaction still completes; done still pulses.
- Reset mid-ACCESS or mid-DONE: the transaction is aborted and no mem_byteen is issued. Reset values apply at the next edge.

## Structure
- Package dm_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the requester index constants (REQ_CPU=0, REQ_AUX=1);
  - the byteen read encoding (BE_READ=4'b0000).
- One natural sub-module: rr_pick2, a combinational 2-way round-robin picker taking (req0, req1, last) and returning (valid, idx). Everything else (latches, counter, FSM) lives in dm_port_arbiter.

## Test plan
- Single read, WAIT_CYCLES=1: memory word 0x4 = 32'hDEADBEEF; r0 reads 0x10 at T.
  - r0_gnt at T+1; r0_done at T+2 with r0_rdata=32'hDEADBEEF.
  - mem_byteen stays 0 throughout.
- Partial write: r1 writes addr 0x22, byteen 4'b1100, wdata 32'hABCD_0000.
  - mem_addr=0x20 and mem_byteen=4'b1100 for exactly one cycle; r1_done one cycle later.
- Contention:
  - Both requesters hold req continuously from reset release. Grant order is r0, r1, r0, r1.
  - Each done precedes the next gnt by 2 cycles; no simultaneous grants.
- Out of range: r0 writes addr 0x0000_4000 (word 4096).
  - mem_byteen never asserts; r0_done and r0_err pulse together; r0_rdata=0.
- WAIT_CYCLES=3 with reset mid-write:
  - r1 write granted at T+1; reset is high at T+2.
  - mem_byteen stays 0; all outputs are at reset values at T+3.
  - A subsequent simultaneous request is granted to r0.
- WAIT_CYCLES=3 latency: r0 read at T gives r0_done at exactly T+4, and the rdata captured equals mem_rdata at T+3.
